// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors, line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Parity bit for a frame, given the XOR of its data bits and the parity type.
  function automatic logic parity_bit(input logic data_xor, input logic par_type);
    logic r;
    r = data_xor;
    unique case (par_type)
      PAR_EVEN: r = data_xor;
      PAR_ODD:  r = ~data_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-timing counters for the UART transmitter: cycle-in-bit and data-bit index.
// Latency: bit_tick asserts combinationally on the last cycle of each P-cycle bit.
// Backpressure: none; counts whenever cnt_en is high, clears when it drops.
module uart_tx_baud_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnt_en,
  input  logic                  bit_en,
  input  logic [PRESCALE_W-1:0] P,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_tick
);

  logic [PRESCALE_W-1:0] w_last;

  assign w_last   = P - PRESCALE_W'(1);
  assign bit_tick = cnt_en && (edge_cnt == w_last);

  // Edge counter wraps at each bit boundary; bit counter advances only on data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (bit_tick) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
      if (bit_tick && bit_en) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte as start, LSB-first data, optional parity, stop.
// Latency: start bit appears on tx_out the cycle after the accept edge.
// Backpressure: requests are only sampled while busy=0; no queuing while a frame is in flight.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_type;

  logic [PRESCALE_W-1:0] w_p;
  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_cnt_en;
  logic                  w_bit_en;
  logic                  w_bit_tick;
  logic                  w_last_bit;
  logic                  w_parity;

  // Prescale of 0 or 1 cannot give a sensible bit period, so it is raised to 2.
  assign w_p        = (r_prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : r_prescale;
  assign w_cnt_en   = (r_state != IDLE);
  assign w_bit_en   = (r_state == DATA);
  assign w_last_bit = (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign w_parity   = parity_bit(^r_data, r_par_type);

  uart_tx_baud_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (w_cnt_en),
    .bit_en   (w_bit_en),
    .P        (w_p),
    .edge_cnt (w_edge_cnt),
    .bit_cnt  (w_bit_cnt),
    .bit_tick (w_bit_tick)
  );

  // Frame sequencer; tx_out/busy/done are set one cycle ahead so they come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_shift    <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      tx_out     <= IDLE_LVL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          tx_out <= IDLE_LVL;
          busy   <= 1'b0;
          if (data_valid) begin
            r_data     <= p_data;
            r_prescale <= prescale;
            r_par_en   <= par_en;
            r_par_type <= par_type;
            r_state    <= START;
            tx_out     <= START_LVL;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (w_bit_tick) begin
            r_state <= DATA;
            tx_out  <= r_data[0];
            r_shift <= r_data >> 1;
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            if (!w_last_bit) begin
              tx_out  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end else if (r_par_en) begin
              r_state <= PARITY;
              tx_out  <= w_parity;
            end else begin
              r_state <= STOP;
              tx_out  <= STOP_LVL;
            end
          end
        end
        PARITY: begin
          if (w_bit_tick) begin
            r_state <= STOP;
            tx_out  <= STOP_LVL;
          end
        end
        STOP: begin
          if (w_bit_tick) begin
            r_state <= IDLE;
            tx_out  <= IDLE_LVL;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          tx_out  <= IDLE_LVL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // The edge counter must never run past the end of a bit.
  a_edge_in_range: assert property (@(posedge clk) disable iff (!rst) w_edge_cnt < w_p);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: randomized frames against a frame-level reference model.
// Latency: checks the start bit in the cycle after accept and the done pulse after the stop bit.
// Backpressure: exercises ignored requests while busy and back-to-back accepts.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic [DW-1:0] p_data     = '0;
  logic          data_valid = 1'b0;
  logic [PW-1:0] prescale   = '0;
  logic          par_en     = 1'b0;
  logic          par_type   = 1'b0;
  logic          tx_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  typedef logic bitq_t[$];

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_type   (par_type),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: bit period and the ordered list of line levels for a frame.
  function automatic int eff_p(input int pre);
    return (pre < 2) ? 2 : pre;
  endfunction

  function automatic bitq_t frame_bits(input logic [DW-1:0] d, input bit pe, input bit pt);
    bitq_t q;
    int ones;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    ones = $countones(d);
    if (pe) q.push_back(((ones % 2) + int'(pt)) % 2 == 1);
    q.push_back(1'b1);
    return q;
  endfunction

  // Present a request at a negedge; returns at the negedge of the first cycle after accept.
  task automatic issue(input logic [DW-1:0] d, input int pre, input bit pe, input bit pt, input bit hold);
    @(negedge clk);
    p_data     = d;
    prescale   = PW'(pre);
    par_en     = pe;
    par_type   = pt;
    data_valid = 1'b1;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Checks a whole frame cycle by cycle, then the done cycle; returns at the done-cycle negedge.
  task automatic check_frame(input logic [DW-1:0] d, input int pre, input bit pe, input bit pt,
                             input string tag, input bit pulse_mid);
    bitq_t bits;
    int p, total, busy_cnt, bad_tx;
    bits     = frame_bits(d, pe, pt);
    p        = eff_p(pre);
    total    = bits.size() * p;
    busy_cnt = 0;
    bad_tx   = 0;
    for (int k = 1; k <= total; k++) begin
      if (k > 1) @(negedge clk);
      if (pulse_mid && k == total / 2) begin
        data_valid = 1'b1;
        p_data     = ~d;
      end else if (pulse_mid && k == total / 2 + 1) begin
        data_valid = 1'b0;
      end
      checks++;
      if (tx_out !== bits[(k-1)/p]) begin
        errors++;
        bad_tx++;
        if (bad_tx <= 4)
          $display("FAIL %s tx_out cycle %0d (bit %0d): got %b expected %b", tag, k, (k-1)/p, tx_out, bits[(k-1)/p]);
      end
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s done early at cycle %0d: got %b expected 0", tag, k, done);
      end
    end
    checks++;
    if (busy_cnt != (2 + DW + int'(pe)) * p) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected %0d", tag, busy_cnt, (2 + DW + int'(pe)) * p);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%b busy=%b tx=%b expected done=1 busy=0 tx=1", tag, done, busy, tx_out);
    end
  endtask

  // Expects the line to sit idle for n cycles.
  task automatic check_idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d: got tx=%b busy=%b done=%b expected 1/0/0", tag, k, tx_out, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b busy=%b done=%b expected 1/0/0", tx_out, busy, done);
    end
    rst = 1'b1;
    check_idle(3, "post_reset");
  endtask

  task automatic test_basic();
    issue(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    check_frame(8'hA5, 8, 1'b0, 1'b0, "basic_a5", 1'b0);
    check_idle(3, "basic_after");
  endtask

  task automatic test_parity();
    issue(8'hA5, 16, 1'b1, 1'b0, 1'b0);
    check_frame(8'hA5, 16, 1'b1, 1'b0, "parity_even", 1'b0);
    issue(8'hA5, 16, 1'b1, 1'b1, 1'b0);
    check_frame(8'hA5, 16, 1'b1, 1'b1, "parity_odd", 1'b0);
  endtask

  task automatic test_capture_isolation();
    issue(8'h07, 4, 1'b1, 1'b0, 1'b0);
    p_data   = 8'hFF;
    prescale = PW'($urandom_range(0, 63));
    par_en   = 1'b0;
    par_type = 1'b1;
    check_frame(8'h07, 4, 1'b1, 1'b0, "capture_07", 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(8'h55, 8, 1'b0, 1'b0, 1'b1);
    p_data = 8'h33;
    check_frame(8'h55, 8, 1'b0, 1'b0, "b2b_first", 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    check_frame(8'h33, 8, 1'b0, 1'b0, "b2b_second", 1'b0);
    check_idle(2, "b2b_after");
    issue(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check_frame(8'h3C, 8, 1'b0, 1'b0, "mid_pulse", 1'b1);
    check_idle(4, "mid_pulse_after");
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    bit            pe;
    d = DW'($urandom) & 8'hF7;
    issue(d, 8, 1'b0, 1'b0, 1'b0);
    repeat (35) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid pre_reset: got tx=%b busy=%b expected 0/1", tx_out, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: got tx=%b busy=%b done=%b expected 1/0/0", tx_out, busy, done);
    end
    check_idle(3, "rst_mid_held");
    rst = 1'b1;
    check_idle(12, "rst_mid_release");
    pe = 1'($urandom);
    issue(8'h81, 8, pe, 1'b0, 1'b0);
    check_frame(8'h81, 8, pe, 1'b0, "rst_mid_81", 1'b0);
  endtask

  task automatic test_prescale_bounds();
    int pres[3] = '{0, 1, 63};
    logic [DW-1:0] d;
    bit pe, pt;
    foreach (pres[i]) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      issue(d, pres[i], pe, pt, 1'b0);
      check_frame(d, pres[i], pe, pt, $sformatf("prescale_%0d", pres[i]), 1'b0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int pre;
    bit pe, pt;
    for (int n = 0; n < 8; n++) begin
      d   = DW'($urandom);
      pre = $urandom_range(2, 12);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      issue(d, pre, pe, pt, 1'b0);
      check_frame(d, pre, pe, pt, $sformatf("random_%0d", n), 1'b0);
      check_idle($urandom_range(0, 3), "random_gap");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_capture_isolation();
    test_back_to_back();
    test_reset_mid_frame();
    test_prescale_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
